// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-request and display bus between vga_timing_gen and its frame buffer / pad side.
interface vga_timing_gen_if #(
  parameter int DEEP_COLOR = 1,
  parameter int CNT_W = 10
);
  logic pix_en, test_en, req_valid, frame_start, HS, VS, DE;
  logic [31:0] pixel;
  logic [CNT_W-1:0] req_col, req_line;
  logic [DEEP_COLOR-1:0] R, G, B;
  modport master(
    input pix_en, pixel, test_en,
    output req_valid, req_col, req_line, frame_start, R, G, B, HS, VS, DE
  );
  modport slave(
    output pix_en, pixel, test_en,
    input req_valid, req_col, req_line, frame_start, R, G, B, HS, VS, DE
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster generator with pixel prefetch and latency-aligned HS/VS/DE/RGB.
// Optional colour-bar test pattern built only when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int DEEP_COLOR = 1,
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0,
  parameter int PIXEL_LATENCY = 1,
  parameter int CNT_W = 10
) (
  input logic clk,
  input logic rst,
  vga_timing_gen_if.master vga_if
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int L = PIXEL_LATENCY;
  localparam int DC = DEEP_COLOR;
  localparam logic [CNT_W:0] HA = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] HS0 = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS1 = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] VA = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] VS0 = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS1 = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] HL = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VL = CNT_W'(V_TOTAL - 1);
  localparam logic HS_ON = HS_POL != 0;
  localparam logic VS_ON = VS_POL != 0;
  logic [CNT_W-1:0] col_q, col_d, line_q, line_d;
  logic col_last, frame_last, de_raw, hs_raw, vs_raw;
  logic [6:0][2:0] sh_q;
  logic [7:0][2:0] ch;
  logic [2:0] t;
  logic [23:0] pix_s;
  logic [DC-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic de_q, hs_q, vs_q, fs_q;
  logic unused_ok;
  always_comb begin
    col_last = col_q == HL;
    frame_last = col_last && line_q == VL;
    col_d = col_last ? '0 : col_q + CNT_W'(1);
    line_d = col_last ? (line_q == VL ? '0 : line_q + CNT_W'(1)) : line_q;
    de_raw = {1'b0, col_q} < HA && {1'b0, line_q} < VA;
    hs_raw = {1'b0, col_q} >= HS0 && {1'b0, col_q} < HS1;
    vs_raw = {1'b0, line_q} >= VS0 && {1'b0, line_q} < VS1;
    // tap 0 is the live request; tap L is the request whose pixel arrives this tick
    ch = {sh_q, {de_raw, hs_raw, vs_raw}};
    t = ch[L];
    r_d = t[2] ? pix_s[23 -: DC] : '0;
    g_d = t[2] ? pix_s[15 -: DC] : '0;
    b_d = t[2] ? pix_s[7 -: DC] : '0;
  end
`ifdef VGA_TEST_PATTERN_EN
  logic [6:0][CNT_W-1:0] col_sh_q;
  logic [7:0][CNT_W-1:0] col_ch;
  logic [CNT_W-1:0] c;
  always_comb begin
    col_ch = {col_sh_q, col_q};
    c = col_ch[L];
    pix_s = vga_if.test_en ? {{8{c[5]}}, {8{c[6]}}, {8{c[7]}}} : vga_if.pixel[23:0];
  end
  always_ff @(posedge clk)
    if (rst) col_sh_q <= '0;
    else if (vga_if.pix_en) col_sh_q <= col_ch[6:0];
  assign unused_ok = ^{vga_if.pixel[31:24], ch, col_ch};
`else
  assign pix_s = vga_if.pixel[23:0];
  assign unused_ok = ^{vga_if.pixel[31:24], vga_if.test_en, ch};
`endif
  always_ff @(posedge clk)
    if (rst) begin
      col_q <= '0;
      line_q <= '0;
      sh_q <= '0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      de_q <= 1'b0;
      hs_q <= ~HS_ON;
      vs_q <= ~VS_ON;
      fs_q <= 1'b0;
    end else begin
      fs_q <= vga_if.pix_en && frame_last;
      if (vga_if.pix_en) begin
        col_q <= col_d;
        line_q <= line_d;
        sh_q <= ch[6:0];
        r_q <= r_d;
        g_q <= g_d;
        b_q <= b_d;
        de_q <= t[2];
        hs_q <= t[1] ? HS_ON : ~HS_ON;
        vs_q <= t[0] ? VS_ON : ~VS_ON;
      end
    end
  assign vga_if.req_valid = de_raw;
  assign vga_if.req_col = col_q;
  assign vga_if.req_line = line_q;
  assign vga_if.frame_start = fs_q;
  assign vga_if.R = r_q;
  assign vga_if.G = g_q;
  assign vga_if.B = b_q;
  assign vga_if.DE = de_q;
  assign vga_if.HS = hs_q;
  assign vga_if.VS = vs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random pix_en/pixel/rst stimulus on a small raster, checked against a tick-count model.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HSY = 3, HB = 2;
  localparam int VA = 4, VF = 1, VSY = 2, VB = 1;
  localparam int L = 2, DC = 4, CW = 6;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int n = 0;
  bit fs_e = 1'b0;
  logic [31:0] last_pix = '0;
  vga_timing_gen_if #(.DEEP_COLOR(DC), .CNT_W(CW)) vif();
  vga_timing_gen #(
    .DEEP_COLOR(DC), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1), .VS_POL(0), .PIXEL_LATENCY(L), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga_if(vif)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h tick=%0d", tag, obs, exp, n);
    end
  endtask
  // n counts pixel ticks since reset; every output is a pure function of n and the last sampled pixel
  task automatic step(input bit r, input bit en);
    int c, l, k, kc, kl;
    bit de_e, hs_e, vs_e;
    logic [31:0] px;
    @(negedge clk);
    px = $urandom;
    rst = r;
    vif.pix_en = en;
    vif.pixel = px;
    vif.test_en = 1'($urandom);
    @(posedge clk);
    if (r) begin
      n = 0;
      fs_e = 1'b0;
    end else if (en) begin
      last_pix = px;
      n++;
      fs_e = (n % FT) == 0;
    end else fs_e = 1'b0;
    #1;
    c = n % HT;
    l = (n / HT) % VT;
    chk("req_col", 32'(vif.req_col), 32'(c));
    chk("req_line", 32'(vif.req_line), 32'(l));
    chk("req_valid", 32'(vif.req_valid), 32'(c < HA && l < VA));
    chk("frame_start", 32'(vif.frame_start), 32'(fs_e));
    de_e = 1'b0;
    hs_e = 1'b0;
    vs_e = 1'b0;
    if (n > L) begin
      k = n - L - 1;
      kc = k % HT;
      kl = (k / HT) % VT;
      de_e = kc < HA && kl < VA;
      hs_e = kc >= HA + HF && kc < HA + HF + HSY;
      vs_e = kl >= VA + VF && kl < VA + VF + VSY;
    end
    chk("DE", 32'(vif.DE), 32'(de_e));
    chk("HS", 32'(vif.HS), 32'(hs_e));
    chk("VS", 32'(vif.VS), 32'(!vs_e));
    chk("R", 32'(vif.R), de_e ? 32'(last_pix[23:20]) : 32'(0));
    chk("G", 32'(vif.G), de_e ? 32'(last_pix[15:12]) : 32'(0));
    chk("B", 32'(vif.B), de_e ? 32'(last_pix[7:4]) : 32'(0));
  endtask
  initial begin
    repeat (3) step(1'b1, 1'($urandom));
    repeat (400) step(1'b0, 1'b1);
    repeat (600) step(1'b0, $urandom_range(0, 99) < 60);
    repeat (37) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (200) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (300) step(1'b0, 1'($urandom));
    repeat (600) step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Parametrised VGA raster generator; next generation of the fixed 640x480 generator/sync pair.
- Every timing field is a parameter: active area, porches, sync widths and sync polarity.
- Runs off a system clock gated by a pixel-clock enable. Issues pixel fetch requests ahead of display so a frame buffer with fixed read latency can feed it.
- Delivers pipeline-aligned HS/VS/DE/RGB to the pad drivers.

## Interface
Parameters:
- DEEP_COLOR, 1 — bits per colour channel at output (1..8)
- H_ACTIVE, 640 — visible pixels per line
- H_FP, 16 — horizontal front porch (ticks)
- H_SYNC, 96 — horizontal sync width
- H_BP, 48 — horizontal back porch
- V_ACTIVE, 480 — visible lines
- V_FP, 10 — vertical front porch (lines)
- V_SYNC, 2 — vertical sync width
- V_BP, 33 — vertical back porch
- HS_POL, 0 — active level of HS (0 = negative)
- VS_POL, 0 — active level of VS
- PIXEL_LATENCY, 1 — ticks from request to pixel data valid (0..7)
- CNT_W, 10 — counter width; H_TOTAL and V_TOTAL must each be ≤ 2**CNT_W

Ports:
- clk  in  1 — system clock
- rst  in  1 — synchronous, active-high reset
- pix_en  in  1 — pixel tick enable; everything except frame_start advances only when 1
- pixel  in  32 — [23:16] R, [15:8] G, [7:0] B, [31:24] ignored
- test_en  in  1 — test-pattern select (used only with macro)
- req_valid  out  1 — req_col/req_line is inside the active area
- req_col  out  CNT_W — column counter
- req_line  out  CNT_W — line counter
- frame_start  out  1 — one-clk pulse at frame wrap
- R, G, B  out  DEEP_COLOR each — colour outputs
- HS, VS  out  1 — sync outputs
- DE  out  1 — display enable, aligned with RGB

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active, front porch, sync, back porch. Column 0 is the first visible pixel.
- Counters: req_col counts 0..H_TOTAL-1 on each tick and wraps to 0. When it wraps, req_line increments; req_line wraps to 0 after V_TOTAL-1.
- Raw signals are decoded from the counters:
  - de_raw = col<H_ACTIVE && line<V_ACTIVE (this is req_valid).
  - hs_raw active for col in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_raw active for line in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Pixel sample: on the tick PIXEL_LATENCY ticks after a request was presented, pixel is sampled.
  - If the delayed de is 1: R/G/B load the top DEEP_COLOR bits of each channel.
  - Otherwise R/G/B load 0 (hard blanking).
- HS/VS/DE: the raw signals pass through a pipeline of PIXEL_LATENCY+1 ticks, so they stay aligned with RGB. Polarity is applied at the last stage (output = raw ? POL : ~POL).
- frame_start: registered; high for exactly one clk after the edge where the counters go from (H_TOTAL-1, V_TOTAL-1) to (0,0). It is not asserted for the frame entered by reset.

## Timing
- Reset values: counters 0; req_valid 1 (position (0,0) is active); R/G/B 0; DE 0; HS = ~HS_POL; VS = ~VS_POL; frame_start 0. All delay pipelines are cleared to inactive.
- rst has priority over pix_en. Reset mid-frame takes effect on the next edge with no completion of the current line. DE stays 0 for PIXEL_LATENCY+1 ticks after release.
- Latency from req presentation to matching R/G/B/DE/HS/VS at outputs: PIXEL_LATENCY+1 ticks. With PIXEL_LATENCY=0, pixel is sampled in the same tick as the request.
- With pix_en=0: no counter, pipeline or output changes.
- Line period is H_TOTAL ticks; frame period is H_TOTAL*V_TOTAL ticks.

## Configuration
- VGA_TEST_PATTERN_EN defined, test_en=1: the sampled pixel is replaced by bars derived from the delayed request column c: R={8{c[5]}}, G={8{c[6]}}, B={8{c[7]}}. Blanking rules are unchanged. test_en=0 behaves normally.
- VGA_TEST_PATTERN_EN undefined: no pattern logic is built; test_en is ignored.

## Test plan
- Defaults, pix_en=1: HS low for exactly 96 clk. It falls 2 clk after req_col=656 appears. Period is 800 clk.
- Defaults: VS low for 1600 clk, starting 2 clk after req_line=490, col=0. frame_start pulses exactly 420000 clk apart, one clk wide.
- PIXEL_LATENCY=2, memory model returning pixel={8'h0, req_col[7:0], req_line[7:0], 8'h5A} delayed 2 ticks, DEEP_COLOR=8: DE rises 3 clk after req_valid. First active pixel: R=0x00, G=0x00, B=0x5A. DE stays high 640 clk.
- DEEP_COLOR=4, pixel=32'h00A5C3F0 held: in the active area R=4'hA, G=4'hC, B=4'hF; in blanking R=G=B=0.
- pix_en toggling 1,0,1,0: HS low for 192 clk, line period 1600 clk. No output changes on clk edges where pix_en=0.
- rst pulsed for 1 clk at req_col=300, line=5: next cycle counters are (0,0) and DE=0, HS=VS inactive. DE returns 2 ticks later at default latency.
